// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter in front of the address mapper
//
// Build option: ARB_TIMEOUT_EN enables the per-transaction watchdog.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   m0_*/m1_*             master side: a, d, we, rd in; spo, ready out
//   bus_a/d/we/rd         to address mapper
//   bus_spo, bus_ready    from address mapper
//   grant                 one-hot current owner (00 = idle)
//   timeout_err           sticky watchdog flag (0 without ARB_TIMEOUT_EN)
module bus_arbiter #(
  parameter logic [31:0] PARK_ADDR = 32'hF000_0000,
  parameter int          TIMEOUT   = 1024,
  parameter int          CNT_W     = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_a,
  input  logic [31:0] m0_d,
  input  logic        m0_we,
  input  logic        m0_rd,
  output logic [31:0] m0_spo,
  output logic        m0_ready,
  input  logic [31:0] m1_a,
  input  logic [31:0] m1_d,
  input  logic        m1_we,
  input  logic        m1_rd,
  output logic [31:0] m1_spo,
  output logic        m1_ready,
  output logic [31:0] bus_a,
  output logic [31:0] bus_d,
  output logic        bus_we,
  output logic        bus_rd,
  input  logic [31:0] bus_spo,
  input  logic        bus_ready,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_G0   = 2'd1,
    S_G1   = 2'd2
  } state_t;

  state_t state;
  logic   last;
  logic   req0, req1;
  logic   to_hit;

  assign req0 = m0_we | m0_rd;
  assign req1 = m1_we | m1_rd;

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  logic [CNT_W-1:0] cnt;

  // Watchdog fires only while the owner still requests and the slave is silent;
  // a slave ready in the same cycle wins.
  assign to_hit = (state != S_IDLE) && (cnt == TO_VAL) && !bus_ready &&
                  ((state == S_G0) ? req0 : req1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        cnt <= '0;
      end else if (!bus_ready) begin
        cnt <= cnt + 1'b1;
      end
      if (to_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign to_hit = 1'b0;
  // No watchdog: constant 0 for every legal configuration; the expression keeps
  // the watchdog parameters referenced in this build.
  assign timeout_err = (CNT_W == 0) && (TIMEOUT == 0);
`endif

  // Bus steering follows the registered grant combinationally.
  always_comb begin
    bus_a    = PARK_ADDR;
    bus_d    = 32'h0;
    bus_we   = 1'b0;
    bus_rd   = 1'b0;
    m0_spo   = 32'h0;
    m1_spo   = 32'h0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    if (state == S_G0) begin
      bus_a    = m0_a;
      bus_d    = m0_d;
      bus_we   = m0_we & ~to_hit;
      bus_rd   = m0_rd & ~to_hit;
      m0_spo   = to_hit ? 32'hDEAD_BEEF : bus_spo;
      m0_ready = req0 & (bus_ready | to_hit);
    end else if (state == S_G1) begin
      bus_a    = m1_a;
      bus_d    = m1_d;
      bus_we   = m1_we & ~to_hit;
      bus_rd   = m1_rd & ~to_hit;
      m1_spo   = to_hit ? 32'hDEAD_BEEF : bus_spo;
      m1_ready = req1 & (bus_ready | to_hit);
    end
  end

  // Every grant ends in IDLE so a request still held after its ready pulse
  // cannot be re-issued, and the other master gets a fair look.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      grant <= 2'b00;
      last  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0 && (!req1 || last)) begin
            state <= S_G0;
            grant <= 2'b01;
          end else if (req1) begin
            state <= S_G1;
            grant <= 2'b10;
          end
        end
        S_G0: begin
          if (!req0) begin
            state <= S_IDLE;
            grant <= 2'b00;
          end else if (bus_ready || to_hit) begin
            state <= S_IDLE;
            grant <= 2'b00;
            last  <= 1'b0;
          end
        end
        S_G1: begin
          if (!req1) begin
            state <= S_IDLE;
            grant <= 2'b00;
          end else if (bus_ready || to_hit) begin
            state <= S_IDLE;
            grant <= 2'b00;
            last  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule
